display_scan_scheduler: RTL

- Shares one serial binary-to-BCD converter between two count sources: A (bottles filled) and B (boxes sealed).
- Arbitrates conversion requests round-robin and stores each result in a per-channel BCD bank.
- Time-multiplexes a 4-digit common-anode 7-segment display from the bank chosen by disp_sel.
- Sits between the bottling-line counters and the board display pins.

---
 rtl/display_pkg.sv | 25 ++
 rtl/serial_bin2bcd.sv | 44 ++++
 rtl/display_scan_scheduler.sv | 106 ++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the display scan scheduler: FSM states,
// channel IDs, default sizing and the active-low 7-segment table.
package display_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    localparam int WIDTH_DEF    = 13;
    localparam int SCAN_DIV_DEF = 50000;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry n is the a..g pattern for digit n (index 9 is written first).
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        return (nib > 4'd9) ? SEG_BLANK : SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/serial_bin2bcd.sv
// Serial double-dabble converter: start loads the operand, each shift cycle
// processes one bit, done flags the final shift cycle.
module serial_bin2bcd
    import display_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             shift,
    input  logic [WIDTH-1:0] bin,
    output logic             done,
    output logic [15:0]      bcd
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic [15:0]      adj;

    for (genvar i = 0; i < 4; i++) begin : g_adj
        assign adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr  <= '0;
            bcd <= '0;
            cnt <= '0;
        end else if (start) begin
            sr  <= bin;
            bcd <= '0;
            cnt <= CW'(WIDTH);
        end else if (shift) begin
            {bcd, sr} <= {adj[14:0], sr, 1'b0};
            cnt       <= cnt - 1'b1;
        end
    end

    assign done = shift && (cnt == CW'(1));

endmodule

// File: rtl/display_scan_scheduler.sv
// Round-robin sharing of one serial BCD converter between two counters, with
// a multiplexed 4-digit display. LEADING_ZERO_BLANK_EN blanks leading zeros.
module display_scan_scheduler
    import display_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int SCAN_DIV = SCAN_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic [WIDTH-1:0] val_a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] val_b,
    output logic             ack_b,
    input  logic             disp_sel,
    output logic             busy,
    output logic [6:0]       seg_n,
    output logic [3:0]       an_n
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t          state, state_nx;
    logic            last_grant, grant_nx;
    logic            conv_done;
    logic [15:0]     conv_bcd;
    logic [1:0][15:0] bank;
    logic [PW-1:0]   presc;
    logic [1:0]      idx, idx_nx;
    logic            tick, blank;
    logic [15:0]     shown;
    logic [3:0]      nib;

    always_comb begin
        state_nx = state;
        grant_nx = last_grant;
        case (state)
            IDLE: if (req_a || req_b) begin
                state_nx = LOAD;
                if (req_a && req_b) grant_nx = ~last_grant;
                else                grant_nx = req_a ? CH_A : CH_B;
            end
            LOAD:    state_nx = SHIFT;
            SHIFT:   if (conv_done) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // last_grant doubles as the current grant from LOAD through DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= CH_B;
            bank       <= '0;
        end else begin
            state      <= state_nx;
            last_grant <= grant_nx;
            if (state == DONE) bank[last_grant] <= conv_bcd;
        end
    end

    assign busy  = (state != IDLE);
    assign ack_a = (state == DONE) && (last_grant == CH_A);
    assign ack_b = (state == DONE) && (last_grant == CH_B);

    serial_bin2bcd #(.WIDTH(WIDTH)) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (state == LOAD),
        .shift (state == SHIFT),
        .bin   (last_grant ? val_b : val_a),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign tick   = (presc == PW'(SCAN_DIV - 1));
    assign idx_nx = idx + 2'd1;
    assign shown  = bank[disp_sel];
    assign nib    = shown[{idx_nx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    assign blank = (idx_nx != 2'd0) && ((shown >> {idx_nx, 2'b00}) == 16'd0);
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
            seg_n <= SEG_BLANK;
            an_n  <= 4'hF;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                idx   <= idx_nx;
                seg_n <= blank ? SEG_BLANK : seg_encode(nib);
                an_n  <= ~(4'b0001 << idx_nx);
            end
        end
    end

endmodule
